// File: rtl/shared_alu_arbiter.sv
// Round-robin arbiter that shares one combinational add/multiply datapath
// among NREQ valid/ready requesters and returns results through a single
// registered response channel tagged with the winning requester's index.
module shared_alu_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_op,
  input  logic [NREQ*WIDTH-1:0] req_left,
  input  logic [NREQ*WIDTH-1:0] req_right,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_out,
  input  logic                  resp_ready
);

  localparam int unsigned LAST = NREQ - 1;

  logic [IDW-1:0]   prio_ptr;
  logic             can_accept;
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   next_ptr;
  int unsigned      cand;
  logic [IDW-1:0]   cand_idx;

  logic [WIDTH-1:0] left_arr  [NREQ];
  logic [WIDTH-1:0] right_arr [NREQ];
  logic [WIDTH-1:0] sel_left;
  logic [WIDTH-1:0] sel_right;
  logic             sel_op;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] mul_res;
  logic [WIDTH-1:0] alu_res;

  // Requests are ignored while reset is held so no grant leaks out of reset.
  assign can_accept = reset_n && (!resp_valid || resp_ready);

  // Split the packed operand buses into per-requester words.
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      left_arr[i]  = req_left[i*WIDTH +: WIDTH];
      right_arr[i] = req_right[i*WIDTH +: WIDTH];
    end
  end

  // Rotating priority search: first valid requester at or after prio_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    if (can_accept) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        cand = 32'(prio_ptr) + k;
        if (cand >= NREQ) begin
          cand = cand - NREQ;
        end
        cand_idx = IDW'(cand);
        if (!grant_found && req_valid[cand_idx]) begin
          grant_found = 1'b1;
          grant_idx   = cand_idx;
        end
      end
    end
  end

  // One-hot grant; the winner's request is accepted in this same cycle.
  always_comb begin
    req_ready = '0;
    if (grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Shared single-cycle datapath fed by the winner's operands; results keep
  // only the low WIDTH bits of the sum or product.
  always_comb begin
    sel_left  = left_arr[grant_idx];
    sel_right = right_arr[grant_idx];
    sel_op    = req_op[grant_idx];
    add_res   = sel_left + sel_right;
    mul_res   = sel_left * sel_right;
    alu_res   = sel_op ? mul_res : add_res;
  end

  // Pointer moves just past the winner, wrapping from the last requester.
  assign next_ptr = (grant_idx == IDW'(LAST)) ? '0 : grant_idx + IDW'(1);

  // Response register and priority pointer; pointer only advances on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_out   <= '0;
      prio_ptr   <= '0;
    end else if (grant_found) begin
      resp_valid <= 1'b1;
      resp_id    <= grant_idx;
      resp_out   <= alu_res;
      prio_ptr   <= next_ptr;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shared_alu_arbiter.sv
// Directed + randomized bench for shared_alu_arbiter with a behavioural
// reference model (pointer, pending requests, single result slot).
module tb_shared_alu_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned IDW   = 2;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_op;
  logic [NREQ*WIDTH-1:0] req_left;
  logic [NREQ*WIDTH-1:0] req_right;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_out;
  logic                  resp_ready;

  shared_alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_left  (req_left),
    .req_right (req_right),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_id   (resp_id),
    .resp_out  (resp_out),
    .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pending requests as presented by the requesters.
  logic [NREQ-1:0]  pv;
  logic [NREQ-1:0]  pop;
  logic [WIDTH-1:0] pl [NREQ];
  logic [WIDTH-1:0] pr [NREQ];

  // Reference model state.
  int               m_ptr;
  bit               m_valid;
  logic [IDW-1:0]   m_id;
  logic [WIDTH-1:0] m_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_id    = '0;
    m_out   = '0;
  endtask

  // Winner per the round-robin rule, or -1 when nothing may be granted.
  function automatic int model_grant();
    if (m_valid && !resp_ready) return -1;
    for (int k = 0; k < int'(NREQ); k++) begin
      int idx;
      idx = (m_ptr + k) % int'(NREQ);
      if (pv[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic drive();
    req_valid = pv;
    req_op    = pop;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_left[i*WIDTH +: WIDTH]  = pl[i];
      req_right[i*WIDTH +: WIDTH] = pr[i];
    end
  endtask

  task automatic req(input int idx, input logic op, input logic [31:0] l, input logic [31:0] r);
    pv[idx]  = 1'b1;
    pop[idx] = op;
    pl[idx]  = l;
    pr[idx]  = r;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'hFFFF_FFFF;
      1: return 32'h0;
      2: return 32'h1;
      3: return 32'h0001_0000;
      default: return $urandom;
    endcase
  endfunction

  // One clock: check grant against the model (and an optional fixed winner,
  // -2 = skip fixed-winner check, -1 = no grant), then check the registered response.
  task automatic cycle(input int ge);
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] const_rdy;
    drive();
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (ge != -2) begin
      const_rdy = '0;
      if (ge >= 0) const_rdy[ge] = 1'b1;
      check("grant_order", 32'(req_ready), 32'(const_rdy));
    end
    @(posedge clk);
    if (g >= 0) begin
      m_out   = pop[g] ? pl[g] * pr[g] : pl[g] + pr[g];
      m_id    = IDW'(g);
      m_valid = 1'b1;
      m_ptr   = (g + 1) % int'(NREQ);
      pv[g]   = 1'b0;
    end else if (m_valid && resp_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check("resp_valid", 32'(resp_valid), 32'(m_valid));
    check("resp_id", 32'(resp_id), 32'(m_id));
    check("resp_out", resp_out, m_out);
  endtask

  initial begin
    pv = '0;
    pop = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      pl[i] = '0;
      pr[i] = '0;
    end
    resp_ready = 1'b1;
    model_reset();

    // Reset: requests present but ignored, outputs cleared.
    reset_n = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) req(i, 1'b0, 32'(i), 32'(i));
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(resp_valid), 32'h0);
    check("rst_id", 32'(resp_id), 32'h0);
    check("rst_out", resp_out, 32'h0);
    pv = '0;
    drive();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single add request on requester 2.
    req(2, 1'b0, 32'd7, 32'd5);
    cycle(2);
    check("single_id", 32'(resp_id), 32'd2);
    check("single_out", resp_out, 32'd12);
    cycle(-1);
    check("drain_valid", 32'(resp_valid), 32'd0);

    // Truncation cases (pointer is now 3).
    req(3, 1'b1, 32'h0001_0000, 32'h0001_0000);
    cycle(3);
    check("trunc_mul", resp_out, 32'h0);
    req(0, 1'b0, 32'hFFFF_FFFF, 32'h1);
    cycle(0);
    check("trunc_add", resp_out, 32'h0);
    req(1, 1'b1, 32'hFFFF_FFFF, 32'h2);
    cycle(1);
    check("trunc_mul2", resp_out, 32'hFFFF_FFFE);

    // Wrap and skip: move pointer to 3, then only requester 1 is valid.
    req(2, 1'b0, 32'd1, 32'd2);
    cycle(2);
    req(1, 1'b1, 32'd6, 32'd7);
    cycle(1);
    check("wrap_out", resp_out, 32'd42);
    req(3, 1'b0, 32'd100, 32'd23);
    cycle(3);
    check("skip_id", 32'(resp_id), 32'd3);
    check("skip_out", resp_out, 32'd123);

    // Round robin with all requesters continuously valid.
    for (int i = 0; i < int'(NREQ); i++) req(i, 1'(i % 2), rand_val(), rand_val());
    for (int n = 0; n < 8; n++) begin
      cycle(n % 4);
      check("rr_id", 32'(resp_id), 32'(n % 4));
      req(n % 4, 1'($urandom_range(0, 1)), rand_val(), rand_val());
    end

    // Backpressure: result held, no grants for 5 cycles.
    resp_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      cycle(-1);
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_id", 32'(resp_id), 32'd3);
    end
    resp_ready = 1'b1;
    cycle(0);
    check("bp_release_id", 32'(resp_id), 32'd0);

    // Asynchronous reset while FULL.
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(resp_valid), 32'h0);
    check("arst_out", resp_out, 32'h0);
    check("arst_ready", 32'(req_ready), 32'h0);
    model_reset();
    pv = '0;
    drive();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(NREQ); i++) req(i, 1'b0, 32'(10 + i), 32'd1);
    cycle(0);
    check("arst_first_id", 32'(resp_id), 32'd0);
    check("arst_first_out", resp_out, 32'd11);

    // Randomized protocol-compliant traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!pv[i] && ($urandom_range(0, 1) == 1)) begin
          req(i, 1'($urandom_range(0, 1)), rand_val(), rand_val());
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      cycle(-2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
